// File: rtl/adder24_arb_pkg.sv
// rtl/adder24_arb_pkg.sv - shared types, widths and helpers for the 24-bit adder arbiter
package adder24_arb_pkg;

   localparam int ADD_W = 24;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   // Ceiling log2, used to size requester IDs from N_REQ.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adder24_rr_pick.sv
// rtl/adder24_rr_pick.sv - combinational round-robin picker
// Ports:
//   req     in  N_REQ  request vector
//   rr_ptr  in  ID_W   index where the search starts (wraps modulo N_REQ)
//   onehot  out N_REQ  one-hot winner, zero when no request
//   idx     out ID_W   winner index, zero when no request
//   any     out 1      at least one request present
module adder24_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/cla_ripple_24bit.sv
// rtl/cla_ripple_24bit.sv - 24-bit adder built from 4-bit lookahead blocks with ripple between blocks
// Ports:
//   a, b  in  24  operands
//   cin   in  1   carry-in
//   sum   out 24  a + b + cin modulo 2^24
//   cout  out 1   carry out of bit 23
module cla_ripple_24bit (
   input  logic [23:0] a,
   input  logic [23:0] b,
   input  logic        cin,
   output logic [23:0] sum,
   output logic        cout
);

   logic [6:0] c;

   assign c[0] = cin;

   for (genvar n = 0; n < 6; n++) begin : g_nib
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] cc;

      assign g = a[4*n +: 4] & b[4*n +: 4];
      assign p = a[4*n +: 4] ^ b[4*n +: 4];

      // Carries inside the nibble are flattened; only nibble carries ripple.
      assign cc[0] = c[n];
      assign cc[1] = g[0] | (p[0] & cc[0]);
      assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
      assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cc[0]);
      assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & cc[0]);

      assign sum[4*n +: 4] = p ^ cc[3:0];
      assign c[n+1]        = cc[4];
   end

   assign cout = c[6];

endmodule

// File: rtl/adder24_rr_arbiter.sv
// rtl/adder24_rr_arbiter.sv - round-robin sharing of one 24-bit adder with a registered valid/ready result
// Optional feature macro: ADDER24_CHAIN_EN (adds req_chain and multi-beat carry chaining).
// Ports:
//   clk, rst_n  in        clock, synchronous active-low reset
//   req         in  N     per-requester request, held with operands until gnt
//   a_flat      in  24*N  operand A, requester i at [24*i+23:24*i]
//   b_flat      in  24*N  operand B, same packing
//   cin         in  N     per-requester carry-in
//   req_chain   in  N     (ADDER24_CHAIN_EN only) chain the next beat of this requester
//   gnt         out N     one-hot accept strobe, same cycle as capture
//   out_valid   out 1     result valid
//   out_ready   in  1     downstream accepts result
//   out_sum     out 24    registered sum
//   out_cout    out 1     registered carry-out
//   out_id      out ID_W  requester that produced out_sum
module adder24_rr_arbiter
   import adder24_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [ADD_W*N_REQ-1:0] a_flat,
   input  logic [ADD_W*N_REQ-1:0] b_flat,
   input  logic [N_REQ-1:0]       cin,
`ifdef ADDER24_CHAIN_EN
   input  logic [N_REQ-1:0]       req_chain,
`endif
   output logic [N_REQ-1:0]       gnt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADD_W-1:0]       out_sum,
   output logic                   out_cout,
   output logic [ID_W-1:0]        out_id
);

   arb_state_t       state;
   logic [ID_W-1:0]  rr_ptr;

   logic [N_REQ-1:0] pick_onehot;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_any;

   logic             accept;
   logic             grant;
   logic [ID_W-1:0]  win;
   logic             cin_sel;
   logic [ID_W-1:0]  ptr_next;

   logic [ADD_W-1:0] add_a;
   logic [ADD_W-1:0] add_b;
   logic [ADD_W-1:0] add_sum;
   logic             add_cout;

   adder24_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // A stalled full register blocks new captures; an empty one always accepts.
   assign accept = (state == EMPTY) | out_ready;

`ifdef ADDER24_CHAIN_EN
   logic             lock;
   logic [ID_W-1:0]  lock_id;

   // While locked only the chaining requester may win, and its carry-in comes
   // from the previous beat's registered carry-out.
   always_comb begin
      win     = pick_idx;
      grant   = 1'b0;
      cin_sel = 1'b0;
      gnt     = '0;
      if (lock) begin
         win     = lock_id;
         grant   = rst_n & accept & req[lock_id];
         cin_sel = out_cout;
         if (grant) gnt[lock_id] = 1'b1;
      end else begin
         grant   = rst_n & accept & pick_any;
         cin_sel = cin[pick_idx];
         if (grant) gnt = pick_onehot;
      end
   end
`else
   always_comb begin
      win     = pick_idx;
      grant   = rst_n & accept & pick_any;
      cin_sel = cin[pick_idx];
      gnt     = grant ? pick_onehot : '0;
   end
`endif

   assign ptr_next = ID_W'((int'(win) + 1) % N_REQ);

   assign add_a = a_flat[ADD_W*win +: ADD_W];
   assign add_b = b_flat[ADD_W*win +: ADD_W];

   cla_ripple_24bit u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (cin_sel),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Result register and FSM. out_sum/out_cout are kept when draining to
   // EMPTY so a chained beat can still read the previous carry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_id    <= '0;
         rr_ptr    <= '0;
`ifdef ADDER24_CHAIN_EN
         lock      <= 1'b0;
         lock_id   <= '0;
`endif
      end else begin
         if (grant) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_cout  <= add_cout;
            out_id    <= win;
`ifdef ADDER24_CHAIN_EN
            if (req_chain[win]) begin
               lock    <= 1'b1;
               lock_id <= win;
            end else begin
               lock    <= 1'b0;
               rr_ptr  <= ptr_next;
            end
`else
            rr_ptr    <= ptr_next;
`endif
         end else if ((state == FULL) && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adder24_rr_arbiter.sv
// tb/tb_adder24_rr_arbiter.sv - self-checking bench with behavioural model for adder24_rr_arbiter
module tb_adder24_rr_arbiter;

   localparam int N = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [24*N-1:0] a_flat;
   logic [24*N-1:0] b_flat;
   logic [N-1:0]  cin;
   logic [N-1:0]  req_chain;
   logic [N-1:0]  gnt;
   logic          out_valid;
   logic          out_ready;
   logic [23:0]   out_sum;
   logic          out_cout;
   logic [1:0]    out_id;

   adder24_rr_arbiter #(.N_REQ(N), .ID_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .cin       (cin),
`ifdef ADDER24_CHAIN_EN
      .req_chain (req_chain),
`endif
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model state
   int          m_ptr;
   bit          m_full;
   logic [23:0] m_sum;
   bit          m_cout;
   int          m_id;
   bit          m_lock;
   int          m_lock_id;
   logic [N-1:0] g_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic set_op(input int i, input logic [23:0] av, input logic [23:0] bv, input logic c);
      a_flat[24*i +: 24] = av;
      b_flat[24*i +: 24] = bv;
      cin[i]             = c;
   endtask

   // One clock: check gnt against the model, advance the model, check outputs.
   task automatic step();
      int          w;
      bit          acc;
      bit          lk;
      bit          chn;
      bit          ce;
      logic [23:0] av;
      logic [23:0] bv;
      logic [24:0] t;
      #1;
      w   = -1;
      acc = !m_full || out_ready;
      lk  = m_lock;
      if (rst_n && acc) begin
         if (lk) begin
            if (req[m_lock_id]) w = m_lock_id;
         end else begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (w < 0 && req[j]) w = j;
            end
         end
      end
      g_seen = gnt;
      chk("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
      if (!rst_n) begin
         m_full = 0; m_sum = '0; m_cout = 0; m_id = 0; m_ptr = 0; m_lock = 0; m_lock_id = 0;
      end else if (w >= 0) begin
         av  = a_flat[24*w +: 24];
         bv  = b_flat[24*w +: 24];
         ce  = lk ? m_cout : cin[w];
         t   = {1'b0, av} + {1'b0, bv} + 25'(ce);
         chn = 0;
`ifdef ADDER24_CHAIN_EN
         chn = req_chain[w];
`endif
         m_full = 1;
         m_sum  = t[23:0];
         m_cout = t[24];
         m_id   = w;
         if (chn) begin
            m_lock = 1; m_lock_id = w;
         end else begin
            m_lock = 0; m_ptr = (w + 1) % N;
         end
      end else if (out_ready) begin
         m_full = 0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
         chk("out_sum", 32'(out_sum), 32'(m_sum));
         chk("out_cout", 32'(out_cout), 32'(m_cout));
         chk("out_id", 32'(out_id), 32'(m_id));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0]  fair_g [5];
      logic [23:0] held;
      fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      m_ptr = 0; m_full = 0; m_sum = '0; m_cout = 0; m_id = 0; m_lock = 0; m_lock_id = 0;
      rst_n = 1'b0; req = '0; a_flat = '0; b_flat = '0; cin = '0; req_chain = '0; out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      req = 4'b1111;
      do_reset();
      chk("reset_gnt", 32'(g_seen), 32'd0);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", 32'(out_sum), 32'd0);
      chk("reset_cout", 32'(out_cout), 32'd0);
      chk("reset_id", 32'(out_id), 32'd0);

      // Single request
      req = 4'b0001; set_op(0, 24'h00000A, 24'h00000A, 1'b0);
      step();
      chk("single_gnt", 32'(g_seen), 32'h1);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_sum", 32'(out_sum), 32'h14);
      chk("single_id", 32'(out_id), 32'd0);
      req = '0;
      step();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Fairness
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < N; i++) set_op(i, 24'(i * 16 + 1), 24'(i), 1'b0);
      for (int s = 0; s < 5; s++) begin
         step();
         chk("fair_gnt", 32'(g_seen), 32'(fair_g[s]));
         chk("fair_id", 32'(out_id), 32'(s % N));
      end

      // Backpressure: five frozen cycles, then immediate refill
      out_ready = 1'b0;
      held = out_sum;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("bp_gnt", 32'(g_seen), 32'd0);
         chk("bp_sum", 32'(out_sum), 32'(held));
         chk("bp_id", 32'(out_id), 32'd0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release_gnt", 32'(g_seen), 32'h2);
      chk("bp_release_id", 32'(out_id), 32'd1);

      // Carry / wrap
      do_reset();
      req = 4'b0001; set_op(0, 24'hFFFFFF, 24'h000001, 1'b0);
      step();
      chk("wrap1_sum", 32'(out_sum), 32'd0);
      chk("wrap1_cout", 32'(out_cout), 32'd1);
      set_op(0, 24'hFFFFFF, 24'h000000, 1'b1);
      step();
      chk("wrap2_sum", 32'(out_sum), 32'd0);
      chk("wrap2_cout", 32'(out_cout), 32'd1);

      // Reset mid-stall
      out_ready = 1'b0; req = 4'b1111;
      step();
      do_reset();
      chk("mid_reset_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1; req = 4'b1010;
      step();
      chk("post_reset_gnt", 32'(g_seen), 32'h2);

`ifdef ADDER24_CHAIN_EN
      // Two-beat chain on requester 2
      do_reset();
      req = 4'b0100; req_chain = 4'b0100;
      set_op(2, 24'hFFFFFF, 24'h000001, 1'b0);
      step();
      chk("chain1_gnt", 32'(g_seen), 32'h4);
      chk("chain1_sum", 32'(out_sum), 32'd0);
      chk("chain1_cout", 32'(out_cout), 32'd1);
      req = 4'b1111; req_chain = 4'b0000;
      set_op(2, 24'h000000, 24'h000000, 1'b0);
      step();
      chk("chain2_gnt", 32'(g_seen), 32'h4);
      chk("chain2_sum", 32'(out_sum), 32'd1);
      chk("chain2_cout", 32'(out_cout), 32'd0);
      req = 4'b1011;
      step();
      chk("chain_after_gnt", 32'(g_seen), 32'h8);
`endif

      // Randomized traffic
      do_reset();
      req = '0; req_chain = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (g_seen[i] || !req[i]) begin
               req[i] = ($urandom_range(0, 1) == 1);
               set_op(i,
                      ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom),
                      ($urandom_range(0, 3) == 0) ? 24'h000001 : 24'($urandom),
                      1'($urandom));
`ifdef ADDER24_CHAIN_EN
               req_chain[i] = ($urandom_range(0, 3) == 0);
`endif
            end
         end
         out_ready = ($urandom_range(0, 9) < 7);
         rst_n     = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
